// File: rtl/servo_pwm_gen_pkg.sv
// rtl/servo_pwm_gen_pkg.sv - shared state encoding, widths and servo timing constants
package servo_pwm_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int PERIOD_W_DEF = 20;
  localparam int DUTY_W_DEF   = 12;

  // Scales shared with the set-point calculator: 1 kHz period, duty in percent.
  localparam int SERVO_PERIOD_SCALE = 1000;
  localparam int SERVO_DUTY_SCALE   = 100;

endpackage

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - double-buffered servo PWM generator, updates only at period boundaries
module servo_pwm_gen
  import servo_pwm_gen_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DUTY_W   = DUTY_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [DUTY_W-1:0]   dutty,
  input  logic [PERIOD_W-1:0] period,
  output logic                pwm_out,
  output logic                cycle_done,
  output logic                busy,
  output logic                cfg_err
);

  state_t              state;
  logic [PERIOD_W-1:0] cnt;
  logic [DUTY_W-1:0]   duty_sh;
  logic [PERIOD_W-1:0] per_sh;
  logic [DUTY_W-1:0]   duty_pd;
  logic [PERIOD_W-1:0] per_pd;
  logic                pend;

  logic [PERIOD_W-1:0] duty_ext;
  logic [PERIOD_W-1:0] cnt_nxt;
  logic                at_end;
  logic                load_ok;
  logic                load_bad;
  logic [DUTY_W-1:0]   nxt_duty;
  logic [PERIOD_W-1:0] nxt_per;

  // Compare helpers and the values that take effect at the next period boundary;
  // a load on the boundary edge itself beats any older pending values.
  always_comb begin
    duty_ext = PERIOD_W'(duty_sh);
    cnt_nxt  = cnt + PERIOD_W'(1);
    at_end   = (cnt == per_sh - PERIOD_W'(1));
    load_ok  = load && (period != '0);
    load_bad = load && (period == '0);
    nxt_duty = duty_sh;
    nxt_per  = per_sh;
    if (load_ok) begin
      nxt_duty = dutty;
      nxt_per  = period;
    end else if (pend) begin
      nxt_duty = duty_pd;
      nxt_per  = per_pd;
    end
  end

  // FSM, tick counter, shadow/pending buffers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      duty_sh    <= '0;
      per_sh     <= '0;
      duty_pd    <= '0;
      per_pd     <= '0;
      pend       <= 1'b0;
      pwm_out    <= 1'b0;
      cycle_done <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err    <= load_bad;
      cycle_done <= 1'b0;
      case (state)
        IDLE: begin
          pwm_out <= 1'b0;
          busy    <= 1'b0;
          if (load_ok) begin
            duty_sh <= dutty;
            per_sh  <= period;
            pend    <= 1'b0;
            if (en) begin
              cnt     <= '0;
              state   <= RUN;
              busy    <= 1'b1;
              pwm_out <= (dutty != '0);
            end
          end else if (en && (per_sh != '0)) begin
            cnt     <= '0;
            state   <= RUN;
            busy    <= 1'b1;
            pwm_out <= (duty_sh != '0);
          end
        end
        RUN: begin
          if (!at_end) begin
            cnt     <= cnt_nxt;
            pwm_out <= (cnt_nxt < duty_ext);
            if (load_ok) begin
              duty_pd <= dutty;
              per_pd  <= period;
              pend    <= 1'b1;
            end
          end else begin
            // Boundary: latch the next configuration even when stopping so a
            // later restart uses the most recent accepted values.
            cnt        <= '0;
            cycle_done <= 1'b1;
            duty_sh    <= nxt_duty;
            per_sh     <= nxt_per;
            pend       <= 1'b0;
            if (!en) begin
              state   <= IDLE;
              pwm_out <= 1'b0;
              busy    <= 1'b0;
            end else begin
              pwm_out <= (nxt_duty != '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - directed self-checking bench for servo_pwm_gen
module tb_servo_pwm_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [11:0] dutty;
  logic [19:0] period;
  logic        pwm_out;
  logic        cycle_done;
  logic        busy;
  logic        cfg_err;

  int passed;
  int total;
  logic exp_err;

  servo_pwm_gen #(.PERIOD_W(20), .DUTY_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .dutty      (dutty),
    .period     (period),
    .pwm_out    (pwm_out),
    .cycle_done (cycle_done),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // One full period of d/p starting at cnt=0; optional loads at ka/kb and en drop at ken.
  task automatic run_period(input int d, input int p, input bit first,
                            input int ka, input int da, input int pa,
                            input int kb, input int db, input int pb,
                            input int ken);
    logic err_n;
    for (int k = 0; k < p; k++) begin
      chk("pwm_out", 32'(pwm_out), 32'(k < d));
      chk("cycle_done", 32'(cycle_done), 32'((k == 0) && !first));
      chk("busy", 32'(busy), 32'd1);
      chk("cfg_err", 32'(cfg_err), 32'(exp_err));
      if (k == ka) begin
        load = 1'b1; dutty = 12'(da); period = 20'(pa);
      end else if (k == kb) begin
        load = 1'b1; dutty = 12'(db); period = 20'(pb);
      end else begin
        load = 1'b0;
      end
      if (k == ken) en = 1'b0;
      err_n = load && (period == 20'd0);
      step();
      exp_err = err_n;
    end
    load = 1'b0;
  endtask

  initial begin
    passed = 0; total = 0; exp_err = 1'b0;
    rst = 1'b1; en = 1'b0; load = 1'b0; dutty = '0; period = '0;

    // Reset state
    step(); step();
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_cdone", 32'(cycle_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b0;
    step();

    // Basic 3/10 with one-cycle latency, then glitch-free update to 7/20
    en = 1'b1; load = 1'b1; dutty = 12'd3; period = 20'd10;
    step();
    load = 1'b0;
    run_period(3, 10, 1, -1, 0, 0, -1, 0, 0, -1);
    run_period(3, 10, 0, 4, 7, 20, -1, 0, 0, -1);
    // Two loads in one period: last wins
    run_period(7, 20, 0, 2, 1, 4, 5, 2, 6, -1);
    // Load on the boundary edge applies directly
    run_period(2, 6, 0, 5, 4, 8, -1, 0, 0, -1);
    run_period(4, 8, 0, 7, 0, 8, -1, 0, 0, -1);
    // Zero duty
    run_period(0, 8, 0, -1, 0, 0, -1, 0, 0, -1);
    run_period(0, 8, 0, 7, 4095, 50, -1, 0, 0, -1);
    // Duty above period
    run_period(4095, 50, 0, 49, 5, 5, -1, 0, 0, -1);
    // Duty equal to period, plus a rejected load while running
    run_period(5, 5, 0, 2, 1, 0, -1, 0, 0, -1);
    run_period(5, 5, 0, 4, 1, 1, -1, 0, 0, -1);
    // Period of one: cycle_done every cycle
    run_period(1, 1, 0, -1, 0, 0, -1, 0, 0, -1);
    run_period(1, 1, 0, -1, 0, 0, -1, 0, 0, -1);
    run_period(1, 1, 0, 0, 3, 10, -1, 0, 0, -1);

    // Clean stop: en low at cnt=2 finishes the period
    run_period(3, 10, 0, -1, 0, 0, -1, 0, 0, 2);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_cdone", 32'(cycle_done), 32'd1);
    chk("stop_pwm", 32'(pwm_out), 32'd0);
    step();
    chk("idle_cdone", 32'(cycle_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Rejected load in IDLE leaves shadow untouched
    load = 1'b1; dutty = 12'd9; period = 20'd0;
    step();
    load = 1'b0;
    chk("idle_cfg_err", 32'(cfg_err), 32'd1);
    chk("idle_rej_busy", 32'(busy), 32'd0);
    step();
    chk("idle_cfg_err_clr", 32'(cfg_err), 32'd0);
    exp_err = 1'b0;

    // Restart from shadow values
    en = 1'b1;
    step();
    run_period(3, 10, 1, -1, 0, 0, -1, 0, 0, -1);

    // Async reset mid-pulse
    chk("pre_rst_pwm", 32'(pwm_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_pwm", 32'(pwm_out), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_cdone", 32'(cycle_done), 32'd0);
    chk("async_cnt", 32'(dut.cnt), 32'd0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_pwm", 32'(pwm_out), 32'd0);
    end

    // New load after reset
    load = 1'b1; dutty = 12'd2; period = 20'd4;
    step();
    load = 1'b0;
    run_period(2, 4, 1, -1, 0, 0, -1, 0, 0, -1);
    run_period(2, 4, 0, -1, 0, 0, -1, 0, 0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Consumes the tick-count pair (dutty, period) produced by the servo set-point calculator and drives the physical servo PWM pin.
- Holds active values in shadow registers. Updates are applied only at period boundaries, so the servo never sees a truncated or glitched pulse.
- Sits between the set-point calculator and the top-level servo output pin, in the radar sweep path.

Parameters:
- PERIOD_W, 20, width of period input and internal tick counter.
- DUTY_W, 12, width of dutty input; must be <= PERIOD_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  generator enable; sampled every cycle.
- load  in  1  one-cycle strobe: capture dutty/period.
- dutty  in  DUTY_W  high time in clk ticks.
- period  in  PERIOD_W  full PWM period in clk ticks.
- pwm_out  out  1  registered PWM output to servo.
- cycle_done  out  1  one-cycle pulse at each period wrap.
- busy  out  1  high while in RUN.
- cfg_err  out  1  one-cycle pulse when a load with period==0 is rejected.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; counter, shadow duty/period, pending regs and pend flag all go to 0.
  - pwm_out=0, cycle_done=0, busy=0, cfg_err=0 immediately, without waiting for a clock edge.
  - Reset mid-pulse cuts the pulse at once; this is accepted.
- States: IDLE, RUN. busy is 1 exactly when state==RUN and is registered.
- Width rule: dutty is zero-extended to PERIOD_W for every comparison. No arithmetic overflows: the counter never exceeds period-1.
- Rejected load: load with period==0 is ignored in any state. cfg_err pulses the next cycle, and shadow and pending registers are unchanged.
- IDLE:
  - pwm_out=0.
  - On an edge with load=1, en=1, period!=0: shadow regs capture the inputs, cnt<=0, state<=RUN, pwm_out<=(dutty!=0).
  - Latency is one cycle: the first high tick of pwm_out is the cycle after load.
  - load with en=0: shadow regs capture the inputs and the block stays IDLE.
  - en rising with no load: enters RUN using the existing shadow values, provided shadow period!=0.
- RUN, per edge:
  - Not at end (cnt != per_sh-1): cnt<=cnt+1, pwm_out<=((cnt+1) < duty_sh).
  - At end (cnt == per_sh-1): cnt<=0 and cycle_done<=1.
    - If en=0: state<=IDLE, pwm_out<=0, busy<=0. Stopping is always clean at a boundary; en low mid-period does not shorten the pulse.
    - Else: apply pending values if pend=1 and clear pend, then pwm_out<=(new duty_sh != 0).
  - Net effect: pwm_out is high for exactly min(duty_sh, per_sh) ticks of each per_sh-tick period.
- Boundary conditions:
  - duty==0: pwm_out is constantly 0 while RUN.
  - duty >= period: pwm_out is constantly 1 while RUN (100 %).
  - period==1: cycle_done is high every cycle.
- Load while RUN (valid period): pending regs capture the inputs and pend<=1. Multiple loads before a boundary: last wins.
- load on the same edge as end of period: the new values are used directly for the next period and pend is not left set.
- load and en falling together at end of period: the generator stops, and the loaded values remain in shadow for the next start.

Decomposition:
- Shared package:
  - State encoding (IDLE=0, RUN=1).
  - Default widths PERIOD_W/DUTY_W.
  - Servo timing constants reused by the set-point calculator: 1 kHz period scale 1000, duty scale 100.
- No sub-module is needed: a single always block for the FSM/counter plus output registers.
- Optionally split the double-buffer (shadow+pending) into servo_cfg_buf if reused by a second servo channel.

Test Plan:
- Reset/basic period: rst pulse, then en=1, load dutty=3 period=10 -> all outputs 0 during rst; pwm_out high 3 cycles starting the cycle after load, low 7; cycle_done pulses every 10 cycles; busy=1.
- Glitch-free update: running 3/10, load dutty=7 period=20 at cnt=4 -> current period completes as 3/10; next period 7 high / 13 low. Two loads in one period -> only the last applies.
- Edge duties: dutty=0 period=8 -> pwm_out stays 0 and cycle_done still every 8. dutty=4095 period=50 -> pwm_out stays 1. dutty=5 period=5 -> constant 1.
- Rejected config: load period=0 in IDLE and in RUN -> cfg_err one-cycle pulse; state and waveform unchanged.
- Clean stop: en=0 at cnt=2 of 3/10 -> pulse finishes its 3 ticks, remaining ticks complete, cycle_done pulses, busy=0 next cycle; en=1 again restarts with the same values.
- Async reset mid-pulse: rst asserted between edges while pwm_out=1 -> pwm_out, busy, cnt go to 0 before the next clk edge; no output until a new load/en.
